// File: rtl/key_conditioner.sv
// Per-key 2-flop synchroniser, counter debounce FSM and registered press/release edge pulses.
// Level change and pulse appear DB_CYCLES+3 edges after the raw change is first sampled; no backpressure.
module key_conditioner #(
  parameter int N_KEYS    = 4,
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_db,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_press
);

  typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_KEYS-1:0] s1_q, s1_d;
  logic [N_KEYS-1:0] s2_q, s2_d;
  state_t            state_q [N_KEYS];
  state_t            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] key_db_q, key_db_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic              any_press_q, any_press_d;

  always_comb begin
    s1_d      = key_raw;
    s2_d      = s1_q;
    key_db_d  = key_db_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        UP: begin
          if (!s2_q[i]) begin
            state_d[i] = WAIT_DN;
            cnt_d[i]   = '0;
          end
        end
        WAIT_DN: begin
          if (s2_q[i]) begin
            state_d[i] = UP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = DOWN;
            key_db_d[i] = 1'b0;
            press_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        DOWN: begin
          if (s2_q[i]) begin
            state_d[i] = WAIT_UP;
            cnt_d[i]   = '0;
          end
        end
        WAIT_UP: begin
          // a single low sample cancels the release; the count restarts on the next high
          if (!s2_q[i]) begin
            state_d[i] = DOWN;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]    = UP;
            key_db_d[i]   = 1'b1;
            release_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = UP;
          cnt_d[i]   = '0;
        end
      endcase
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '1;
      s2_q        <= '1;
      key_db_q    <= '1;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= UP;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      key_db_q    <= key_db_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign key_db      = key_db_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and random bench for key_conditioner with a run-length reference model.
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int DB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_db, key_press, key_release;
  logic         any_press;

  int errs = 0;
  int nchk = 0;
  int ncyc = 0;

  always #20 clk = ~clk;

  key_conditioner #(.N_KEYS(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .key_db      (key_db),
    .key_press   (key_press),
    .key_release (key_release),
    .any_press   (any_press)
  );

  // Reference: a key's clean level flips once the synchronised input has
  // disagreed with it for DB+1 consecutive clock samples.
  logic [N-1:0] m_s1, m_s2, m_db, m_press, m_rel, m_in;
  logic         m_any;
  int           run [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_db = '1; m_press = '0; m_rel = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      m_in = m_s2; m_s2 = m_s1; m_s1 = key_raw;
      m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
        if (m_in[i] != m_db[i]) begin
          run[i]++;
          if (run[i] == DB + 1) begin
            m_db[i] = m_in[i];
            if (m_in[i] == 1'b0) m_press[i] = 1'b1;
            else                 m_rel[i]   = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_any = |m_press;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, ncyc, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    ncyc++;
    check("model_db",      32'(key_db),      32'(m_db));
    check("model_press",   32'(key_press),   32'(m_press));
    check("model_release", 32'(key_release), 32'(m_rel));
    check("model_any",     32'(any_press),   32'(m_any));
  endtask

  // Counts edges until key_db[idx] reaches val, bounded at 60.
  task automatic wait_db(input int idx, input logic val, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (key_db[idx] !== val && n < 60);
  endtask

  int n, pc, t0, t3, na;

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'b0000;
    cyc(); cyc();
    check("rst_db",      32'(key_db),      32'hF);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_any",     32'(any_press),   32'h0);

    rst_n = 1'b1;
    wait_db(0, 1'b0, n);
    check("exit_latency", 32'(n), 32'd11);
    check("exit_db",      32'(key_db),    32'h0);
    check("exit_press",   32'(key_press), 32'hF);
    check("exit_any",     32'(any_press), 32'h1);
    cyc();
    check("exit_press_w", 32'(key_press), 32'h0);
    check("exit_any_w",   32'(any_press), 32'h0);

    key_raw = 4'hF;
    repeat (14) cyc();
    key_raw[0] = 1'b0;
    wait_db(0, 1'b0, n);
    check("k0_latency", 32'(n), 32'd11);
    check("k0_db",      32'(key_db),    32'hE);
    check("k0_press",   32'(key_press), 32'h1);
    cyc();
    check("k0_press_w", 32'(key_press), 32'h0);

    for (int p = 0; p < 14; p++) begin
      key_raw[2] = 1'(p % 2);
      repeat (3) begin
        cyc();
        check("bounce_db",    32'(key_db[2]),    32'h1);
        check("bounce_press", 32'(key_press[2]), 32'h0);
      end
    end
    key_raw[2] = 1'b0;
    wait_db(2, 1'b0, n);
    check("bounce_latency", 32'(n), 32'd11);
    pc = int'(key_press[2]);
    repeat (15) begin
      cyc();
      pc += int'(key_press[2]);
    end
    check("bounce_npress", 32'(pc), 32'd1);

    key_raw[1] = 1'b0;
    repeat (14) cyc();
    key_raw[1] = 1'b1;
    wait_db(1, 1'b1, n);
    check("rel_latency", 32'(n), 32'd11);
    check("rel_pulse",   32'(key_release), 32'h2);
    check("rel_nopress", 32'(key_press),   32'h0);
    cyc();
    check("rel_pulse_w", 32'(key_release), 32'h0);
    key_raw[1] = 1'b0;
    repeat (14) cyc();
    key_raw[1] = 1'b1;
    repeat (4) cyc();
    key_raw[1] = 1'b0;
    repeat (2) cyc();
    check("glitch_hold", 32'(key_db[1]), 32'h0);
    key_raw[1] = 1'b1;
    wait_db(1, 1'b1, n);
    check("glitch_latency", 32'(n), 32'd11);

    key_raw = 4'hF;
    repeat (14) cyc();
    key_raw[0] = 1'b0;
    t0 = -1; t3 = -1; na = 0;
    for (int t = 1; t <= 25; t++) begin
      cyc();
      if (key_press[0]) t0 = t;
      if (key_press[3]) t3 = t;
      if (any_press)    na++;
      if (t == 2) key_raw[3] = 1'b0;
    end
    check("sim_t0",  32'(t0), 32'd11);
    check("sim_t3",  32'(t3), 32'd13);
    check("sim_any", 32'(na), 32'd2);

    key_raw[1] = 1'b0;
    repeat (8) cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_db",      32'(key_db),      32'hF);
    check("mid_rst_press",   32'(key_press),   32'h0);
    check("mid_rst_release", 32'(key_release), 32'h0);
    cyc();
    rst_n = 1'b1;
    wait_db(1, 1'b0, n);
    check("mid_rst_latency", 32'(n), 32'd11);
    check("mid_rst_db2",     32'(key_db),    32'h4);
    check("mid_rst_press2",  32'(key_press), 32'hB);

    for (int c = 0; c < 1500; c++) begin
      cyc();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) key_raw[i] = ~key_raw[i];
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
